// File: rtl/axi_full_slave_sram.sv
// AXI4 burst-capable slave over a single-clock SRAM array.
// Independent write (AW/W/B) and read (AR/R) engines; responses are in order and always OKAY.
//
// state   | meaning
// W_IDLE  | waiting for AW; AWREADY pulses for one cycle on AWVALID
// W_DATA  | accepting write beats (WREADY=1)
// W_RESP  | BVALID held until BREADY
// R_IDLE  | waiting for AR; ARREADY pulses for one cycle on ARVALID
// R_DATA  | registered beat presented on R until accepted
module axi_full_slave_sram #(
   parameter int DW         = 64,
   parameter int AW         = 32,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic [AW-1:0]     S_AXI_AWADDR,
   input  logic [7:0]        S_AXI_AWLEN,
   input  logic [2:0]        S_AXI_AWSIZE,
   input  logic [1:0]        S_AXI_AWBURST,
   input  logic              S_AXI_AWVALID,
   output logic              S_AXI_AWREADY,
   input  logic [DW-1:0]     S_AXI_WDATA,
   input  logic [DW/8-1:0]   S_AXI_WSTRB,
   input  logic              S_AXI_WLAST,
   input  logic              S_AXI_WVALID,
   output logic              S_AXI_WREADY,
   output logic [1:0]        S_AXI_BRESP,
   output logic              S_AXI_BVALID,
   input  logic              S_AXI_BREADY,
   input  logic [AW-1:0]     S_AXI_ARADDR,
   input  logic [7:0]        S_AXI_ARLEN,
   input  logic [2:0]        S_AXI_ARSIZE,
   input  logic [1:0]        S_AXI_ARBURST,
   input  logic              S_AXI_ARVALID,
   output logic              S_AXI_ARREADY,
   output logic [DW-1:0]     S_AXI_RDATA,
   output logic [1:0]        S_AXI_RRESP,
   output logic              S_AXI_RLAST,
   output logic              S_AXI_RVALID,
   input  logic              S_AXI_RREADY
);

   localparam int NB    = DW / 8;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;

   function automatic logic [2:0] clamp_size(input logic [2:0] s);
      return (s > 3'd3) ? 3'd3 : s;
   endfunction

   // WRAP with an illegal length degrades to INCR; reserved burst code also behaves as INCR.
   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                                 input logic [2:0] size, input logic [1:0] burst);
      logic [AW-1:0] inc;
      logic [AW-1:0] mask;
      logic          wrap_ok;
      inc     = a + (AW'(1) << size);
      mask    = ((AW'(len) + AW'(1)) << size) - AW'(1);
      wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      if (burst == 2'b00)
         return a;
      else if ((burst == 2'b10) && wrap_ok)
         return (a & ~mask) | (inc & mask);
      else
         return inc;
   endfunction

   logic [DW-1:0] mem [DEPTH];

   // ---------------- write engine ----------------
   w_state_t      w_state, w_state_nxt;
   logic          aw_rdy;
   logic [AW-1:0] w_addr;
   logic [7:0]    w_len;
   logic [2:0]    w_size;
   logic [1:0]    w_burst;
   logic [7:0]    w_cnt;
   logic          aw_hs, w_hs, w_last_beat;

   assign S_AXI_AWREADY = aw_rdy;
   assign S_AXI_WREADY  = (w_state == W_DATA);
   assign S_AXI_BVALID  = (w_state == W_RESP);
   assign S_AXI_BRESP   = 2'b00;
   assign aw_hs         = aw_rdy && S_AXI_AWVALID;
   assign w_hs          = S_AXI_WREADY && S_AXI_WVALID;
   assign w_last_beat   = S_AXI_WLAST || (w_cnt == w_len);

   always_comb begin
      w_state_nxt = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
         W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
         W_RESP:  if (S_AXI_BREADY) w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RSTn) begin
         w_state <= W_IDLE;
         aw_rdy  <= 1'b0;
      end else begin
         w_state <= w_state_nxt;
         aw_rdy  <= (w_state == W_IDLE) && S_AXI_AWVALID && !aw_rdy;
      end
   end

   always_ff @(posedge CLK) begin
      if (aw_hs) begin
         w_addr  <= S_AXI_AWADDR;
         w_len   <= S_AXI_AWLEN;
         w_size  <= clamp_size(S_AXI_AWSIZE);
         w_burst <= S_AXI_AWBURST;
         w_cnt   <= 8'd0;
      end else if (w_hs) begin
         w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
         w_cnt  <= w_cnt + 8'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_hs && !RSTn) begin
         for (int b = 0; b < NB; b++) begin
            if (S_AXI_WSTRB[b])
               mem[w_addr[3 +: DEPTH_LOG2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
         end
      end
   end

   // ---------------- read engine ----------------
   r_state_t      r_state, r_state_nxt;
   logic          ar_rdy;
   logic [AW-1:0] r_addr;
   logic [7:0]    r_len;
   logic [2:0]    r_size;
   logic [1:0]    r_burst;
   logic [7:0]    r_cnt;
   logic [DW-1:0] r_data;
   logic          r_last;
   logic          ar_hs, r_hs;

   assign S_AXI_ARREADY = ar_rdy;
   assign S_AXI_RVALID  = (r_state == R_DATA);
   assign S_AXI_RDATA   = r_data;
   assign S_AXI_RLAST   = r_last;
   assign S_AXI_RRESP   = 2'b00;
   assign ar_hs         = ar_rdy && S_AXI_ARVALID;
   assign r_hs          = S_AXI_RVALID && S_AXI_RREADY;

   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
         R_DATA:  if (r_hs && r_last) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RSTn) begin
         r_state <= R_IDLE;
         ar_rdy  <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_state <= r_state_nxt;
         ar_rdy  <= (r_state == R_IDLE) && S_AXI_ARVALID && !ar_rdy;
         if (ar_hs)
            r_last <= (S_AXI_ARLEN == 8'd0);
         else if (r_hs)
            r_last <= r_last ? 1'b0 : ((r_cnt + 8'd1) == r_len);
      end
   end

   // r_addr always points at the beat to fetch next, so each beat is one registered read.
   always_ff @(posedge CLK) begin
      if (ar_hs) begin
         r_data  <= mem[S_AXI_ARADDR[3 +: DEPTH_LOG2]];
         r_addr  <= next_addr(S_AXI_ARADDR, S_AXI_ARLEN, clamp_size(S_AXI_ARSIZE), S_AXI_ARBURST);
         r_len   <= S_AXI_ARLEN;
         r_size  <= clamp_size(S_AXI_ARSIZE);
         r_burst <= S_AXI_ARBURST;
         r_cnt   <= 8'd0;
      end else if (r_hs && !r_last) begin
         r_data <= mem[r_addr[3 +: DEPTH_LOG2]];
         r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
         r_cnt  <= r_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_axi_full_slave_sram.sv
// Directed bench for axi_full_slave_sram: reset, single/burst writes, strobes, FIXED/WRAP,
// read backpressure and concurrent read/write.
module tb_axi_full_slave_sram;

   logic        CLK;
   logic        RSTn;
   logic [31:0] S_AXI_AWADDR;
   logic [7:0]  S_AXI_AWLEN;
   logic [2:0]  S_AXI_AWSIZE;
   logic [1:0]  S_AXI_AWBURST;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [63:0] S_AXI_WDATA;
   logic [7:0]  S_AXI_WSTRB;
   logic        S_AXI_WLAST;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [31:0] S_AXI_ARADDR;
   logic [7:0]  S_AXI_ARLEN;
   logic [2:0]  S_AXI_ARSIZE;
   logic [1:0]  S_AXI_ARBURST;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [63:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RLAST;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;

   axi_full_slave_sram #(.DW(64), .AW(32), .DEPTH_LOG2(10)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWSIZE(S_AXI_AWSIZE),
      .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE),
      .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] wdat [16];
   logic [7:0]  wstb [16];
   logic [63:0] rexp [16];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one AW + nbeats W beats (WLAST on the final one) with SIZE=3, then completes B.
   task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats);
      int cyc;
      S_AXI_AWADDR  = addr;
      S_AXI_AWLEN   = len;
      S_AXI_AWSIZE  = 3'd3;
      S_AXI_AWBURST = burst;
      S_AXI_AWVALID = 1'b1;
      cyc = 0;
      while (!S_AXI_AWREADY && cyc < 50) begin
         @(posedge CLK); #1; cyc++;
      end
      if (!S_AXI_AWREADY) check("aw_timeout", 64'(cyc), 64'd0);
      else begin
         @(posedge CLK); #1;
      end
      S_AXI_AWVALID = 1'b0;
      check("awready_pulse", 64'(S_AXI_AWREADY), 64'd0);
      check("wready_on", 64'(S_AXI_WREADY), 64'd1);
      for (int i = 0; i < nbeats; i++) begin
         S_AXI_WVALID = 1'b1;
         S_AXI_WDATA  = wdat[i];
         S_AXI_WSTRB  = wstb[i];
         S_AXI_WLAST  = (i == nbeats - 1);
         cyc = 0;
         while (!S_AXI_WREADY && cyc < 50) begin
            @(posedge CLK); #1; cyc++;
         end
         @(posedge CLK); #1;
      end
      S_AXI_WVALID = 1'b0;
      S_AXI_WLAST  = 1'b0;
      check("wready_drop", 64'(S_AXI_WREADY), 64'd0);
      check("bvalid", 64'(S_AXI_BVALID), 64'd1);
      check("bresp", 64'(S_AXI_BRESP), 64'd0);
      @(posedge CLK); #1;
      check("bvalid_hold", 64'(S_AXI_BVALID), 64'd1);
      S_AXI_BREADY = 1'b1;
      @(posedge CLK); #1;
      S_AXI_BREADY = 1'b0;
      check("bvalid_clr", 64'(S_AXI_BVALID), 64'd0);
   endtask

   // mode 0: RREADY always 1; mode 1: RREADY one cycle after each RVALID; mode 2: RREADY every 3rd cycle.
   task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode);
      int          cyc, beat, n;
      logic        rr, stall;
      logic [63:0] hold;
      n = int'(len) + 1;
      S_AXI_ARADDR  = addr;
      S_AXI_ARLEN   = len;
      S_AXI_ARSIZE  = size;
      S_AXI_ARBURST = burst;
      S_AXI_ARVALID = 1'b1;
      cyc = 0;
      while (!S_AXI_ARREADY && cyc < 50) begin
         @(posedge CLK); #1; cyc++;
      end
      if (!S_AXI_ARREADY) check("ar_timeout", 64'(cyc), 64'd0);
      else begin
         @(posedge CLK); #1;
      end
      S_AXI_ARVALID = 1'b0;
      check("rvalid_first", 64'(S_AXI_RVALID), 64'd1);
      check("rresp", 64'(S_AXI_RRESP), 64'd0);
      beat = 0; cyc = 0; stall = 1'b0; hold = '0;
      while (beat < n && cyc < 400) begin
         rr = 1'b0;
         if (S_AXI_RVALID) begin
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? stall : (cyc % 3 == 2);
            if (stall) check("r_stable", S_AXI_RDATA, hold);
            if (rr) begin
               check("rdata", S_AXI_RDATA, rexp[beat]);
               check("rlast", 64'(S_AXI_RLAST), 64'(beat == n - 1));
               beat++;
               stall = 1'b0;
            end else begin
               hold  = S_AXI_RDATA;
               stall = 1'b1;
            end
         end
         S_AXI_RREADY = rr;
         @(posedge CLK); #1;
         cyc++;
      end
      S_AXI_RREADY = 1'b0;
      if (beat < n) check("r_timeout", 64'(beat), 64'(n));
      check("rvalid_end", 64'(S_AXI_RVALID), 64'd0);
   endtask

   initial begin
      RSTn = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = 3'd3; S_AXI_AWBURST = 2'b01;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = 3'd3; S_AXI_ARBURST = 2'b01;
      S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

      // reset held with AWVALID asserted
      repeat (2) @(posedge CLK);
      #1;
      check("rst_awready", 64'(S_AXI_AWREADY), 64'd0);
      check("rst_arready", 64'(S_AXI_ARREADY), 64'd0);
      check("rst_wready", 64'(S_AXI_WREADY), 64'd0);
      check("rst_bvalid", 64'(S_AXI_BVALID), 64'd0);
      check("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
      check("rst_rlast", 64'(S_AXI_RLAST), 64'd0);
      check("rst_resp", 64'({S_AXI_BRESP, S_AXI_RRESP}), 64'd0);
      S_AXI_AWVALID = 1'b0;
      RSTn = 1'b0;
      @(posedge CLK); #1;

      // single beat
      wdat[0] = 64'h1; wstb[0] = 8'hFF;
      axi_write(32'h0, 8'd0, 2'b01, 1);
      rexp[0] = 64'h1;
      axi_read(32'h0, 8'd0, 3'd3, 2'b01, 0);

      // 16-beat INCR, data 1..16
      for (int i = 0; i < 16; i++) begin
         wdat[i] = 64'(i + 1); wstb[i] = 8'hFF; rexp[i] = 64'(i + 1);
      end
      axi_write(32'h0, 8'd15, 2'b01, 16);
      axi_read(32'h0, 8'd15, 3'd3, 2'b01, 1);
      axi_read(32'h0, 8'd15, 3'd3, 2'b01, 2);

      // byte strobes on word 1
      wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstb[0] = 8'hFF;
      axi_write(32'h8, 8'd0, 2'b01, 1);
      wdat[0] = 64'h0; wstb[0] = 8'h0F;
      axi_write(32'h8, 8'd0, 2'b01, 1);
      rexp[0] = 64'hFFFF_FFFF_0000_0000;
      axi_read(32'h8, 8'd0, 3'd3, 2'b01, 0);
      wdat[0] = 64'h1234_5678_9ABC_DEF0; wstb[0] = 8'h00;
      axi_write(32'h8, 8'd0, 2'b01, 1);
      axi_read(32'h8, 8'd0, 3'd3, 2'b01, 0);

      // FIXED burst: last beat wins, neighbour untouched
      wdat[0] = 64'hAAAA_0000_0000_000A; wdat[1] = 64'hBBBB_0000_0000_000B;
      wdat[2] = 64'hCCCC_0000_0000_000C; wdat[3] = 64'hDDDD_0000_0000_000D;
      for (int i = 0; i < 4; i++) wstb[i] = 8'hFF;
      axi_write(32'h10, 8'd3, 2'b00, 4);
      rexp[0] = 64'hDDDD_0000_0000_000D; rexp[1] = 64'd4;
      axi_read(32'h10, 8'd1, 3'd3, 2'b01, 0);

      // WRAP read: 0x18, 0x0, 0x8, 0x10
      rexp[0] = 64'd4; rexp[1] = 64'd1; rexp[2] = 64'hFFFF_FFFF_0000_0000;
      rexp[3] = 64'hDDDD_0000_0000_000D;
      axi_read(32'h18, 8'd3, 3'd3, 2'b10, 0);

      // early WLAST: AWLEN=3 but only two beats
      wdat[0] = 64'hE0; wdat[1] = 64'hE1;
      axi_write(32'h20, 8'd3, 2'b01, 2);
      rexp[0] = 64'hE0; rexp[1] = 64'hE1; rexp[2] = 64'd7; rexp[3] = 64'd8;
      axi_read(32'h20, 8'd3, 3'd3, 2'b01, 0);

      // ARSIZE=7 clamps to 8-byte steps; address 0x2000 aliases to word 0
      rexp[0] = 64'd1; rexp[1] = 64'hFFFF_FFFF_0000_0000;
      axi_read(32'h2000, 8'd1, 3'd7, 2'b01, 0);

      // concurrent write burst and read burst
      for (int i = 0; i < 4; i++) begin
         wdat[i] = 64'h51 + 64'(i); wstb[i] = 8'hFF;
      end
      for (int i = 0; i < 16; i++) rexp[i] = 64'(i + 1);
      rexp[1] = 64'hFFFF_FFFF_0000_0000; rexp[2] = 64'hDDDD_0000_0000_000D;
      rexp[4] = 64'hE0; rexp[5] = 64'hE1;
      fork
         axi_write(32'h100, 8'd3, 2'b01, 4);
         axi_read(32'h0, 8'd15, 3'd3, 2'b01, 0);
      join
      for (int i = 0; i < 4; i++) rexp[i] = 64'h51 + 64'(i);
      axi_read(32'h100, 8'd3, 3'd3, 2'b01, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_full_slave_sram.md
Name: axi_full_slave_sram

Overview:
AXI4 (full, burst-capable) slave backed by an internal single-clock SRAM array. It serves as a memory model / on-chip RAM endpoint for cache and bus-master verification. It has independent write (AW/W/B) and read (AR/R) engines. No ID signals; responses are always in order.

Parameters:
DW, 64, data width in bits (byte lanes = DW/8; WSTRB width).
AW, 32, address width in bits.
DEPTH_LOG2, 10, log2 of SRAM depth in DW-bit words (1024 words = 8 KiB).

Ports:
CLK  in  1  clock; all logic on rising edge.
RSTn  in  1  reset; synchronous, active-high (asserted = 1).
S_AXI_AWADDR  in  AW  write burst start byte address.
S_AXI_AWLEN  in  8  write beats minus 1.
S_AXI_AWSIZE  in  3  log2 bytes per beat.
S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
S_AXI_WDATA  in  DW  write data.
S_AXI_WSTRB  in  DW/8  byte enables.
S_AXI_WLAST  in  1  last write beat.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST  in  AW,8,3,2  read burst descriptor; same encodings as AW.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
S_AXI_RDATA  out  DW  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RLAST  out  1  last read beat.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.

Behaviour:
- Reset: AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST = 0; BRESP and RRESP = 00; both engines go to IDLE. Reset mid-burst abandons the burst. SRAM contents are not affected by reset.
- Word index = addr[3 +: DEPTH_LOG2]. Upper address bits are ignored, so addresses alias and wrap modulo the array size.
- SIZE values above 3 are clamped to 3.
- Beat address step = 2^SIZE.
  - FIXED: address constant for the whole burst.
  - INCR: address += step after each beat.
  - WRAP: wraps at a (LEN+1)*step aligned boundary. Only LEN of 1, 3, 7 or 15 is legal for WRAP; any other LEN is treated as INCR.
- Write engine, states IDLE -> WDATA -> BRESP -> IDLE:
  - IDLE: when AWVALID=1, AWREADY pulses high for exactly one cycle (the handshake cycle). The engine latches addr/len/size/burst, clears the beat counter and enters WDATA.
  - WDATA: WREADY=1. Each WVALID&WREADY beat writes the bytes whose WSTRB bit is 1; all other bytes are untouched. WSTRB=0 writes nothing.
  - The burst ends on the beat with WLAST=1 or on beat count == LEN, whichever comes first. WREADY drops in the following cycle.
  - BRESP state: BVALID=1 with BRESP=00 starting the cycle after the last beat. BVALID holds until BREADY=1, then returns to IDLE.
  - AWREADY is never asserted outside IDLE, so a new AW waits for the B handshake.
- Read engine, states IDLE -> RDATA -> IDLE:
  - IDLE: when ARVALID=1, ARREADY pulses high for one cycle and the descriptor is latched.
  - The first RVALID appears the cycle after the AR handshake.
  - RDATA, RLAST and RVALID are registered and must stay stable while RVALID=1 and RREADY=0.
  - With RREADY held at 1, the engine delivers one beat per cycle.
  - RLAST=1 only on beat index LEN. After the last handshake RVALID=0 and the engine returns to IDLE. RRESP=00 always.
- Read and write engines run concurrently. A same-cycle read and write to the same word returns the old data.
- No error responses are generated (SLVERR/DECERR unused).

Test Plan:
1. Hold RSTn=1 for 2 cycles with AWVALID=1 -> AWREADY, ARREADY, WREADY, BVALID and RVALID all 0; BRESP=RRESP=00.
2. Single write AWADDR=0x0, AWLEN=0, WDATA=0x1, WSTRB=0xFF, WLAST=1 -> AWREADY one-cycle pulse; beat accepted; BVALID the next cycle with BRESP=00, held until BREADY. Then ARADDR=0x0, ARLEN=0 -> RDATA=0x1, RLAST=1.
3. Write 16 INCR beats at 0x0 with data 1..16, then read ARLEN=15, ARBURST=01, ARSIZE=3:
   - Sub-case RREADY asserted one cycle after RVALID -> data stays stable until taken.
   - Sub-case RREADY toggling -> RDATA sequence 1..16 with no repeats; RLAST only on the 16th beat.
4. Write 0xFFFF_FFFF_FFFF_FFFF at 0x8 with WSTRB=0xFF, then write 0x0 with WSTRB=0x0F -> readback 0xFFFF_FFFF_0000_0000. Then write with WSTRB=0x00 -> data unchanged and BVALID still issued.
5. FIXED write to 0x10 with AWLEN=3 and data A, B, C, D -> readback at 0x10 = D, and 0x18 unchanged.
6. WRAP read at 0x18 with ARLEN=3 -> beats come from 0x18, 0x0, 0x8, 0x10. Issue an AR while a write burst is active -> both complete correctly.
